// File: rtl/rx_word_assembler_pkg.sv
// Shared constants for the host-to-core UART word receiver.
// Baud divisors are clk12 cycles per UART bit.
package rx_word_assembler_pkg;

  localparam int B9600   = 1250;
  localparam int B19200  = 625;
  localparam int B57600  = 208;
  localparam int B115200 = 104;

  localparam int RX_LITTLE = 0;
  localparam int RX_BIG    = 1;

endpackage

// File: rtl/rx_word_assembler_uart_rx.sv
// 8N1 UART byte receiver; rcv is a one-cycle strobe qualifying data.
// BAUDRATE is the number of clk cycles per bit.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | line idle, waiting for a low level (start bit)
// START | half-bit wait, then confirm start bit still low
// DATA  | sample 8 data bits, LSB first, at bit centres
// STOP  | sample stop bit; strobe rcv if it is high
module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data
);

  localparam int CNT_W = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUDRATE - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((BAUDRATE / 2 > 0) ? BAUDRATE / 2 - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rcv     <= 1'b0;
      data    <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rcv     <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_BIT;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            bit_idx <= '0;
            cnt     <= FULL_BIT;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) state <= STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (cnt == '0) begin
            // A low stop bit is a framing error; the byte is dropped.
            if (rx_s) begin
              rcv  <= 1'b1;
              data <= shift;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Collects WORD_BYTES UART bytes into one word behind a one-deep valid/ready buffer.
//
// state   | meaning
// --------+-------------------------------------
// IDLE    | byte_idx == 0, no partial word held
// COLLECT | at least one byte of a word held
module rx_word_assembler
  import rx_word_assembler_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int BAUDRATE       = B115200,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int BIG_ENDIAN     = RX_LITTLE
) (
  input  logic                    clk12,
  input  logic                    rst,
  input  logic                    rx,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  // A single-byte word can never be partial, so the timeout is meaningless there.
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0) && (WORD_BYTES > 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic             rcv;
  logic [7:0]       rx_byte;
  logic [0:0]       state;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] slot;
  logic [TMO_W-1:0] tmo_cnt;
  logic [W-1:0]     asm_q;
  logic [W-1:0]     asm_next;
  logic             word_done;
  logic             can_load;
  logic             tmo_hit;

  uart_rx #(
    .BAUDRATE (BAUDRATE)
  ) u_uart_rx (
    .clk  (clk12),
    .rstn (~rst),
    .rx   (rx),
    .rcv  (rcv),
    .data (rx_byte)
  );

  always_comb begin
    slot = (BIG_ENDIAN != 0) ? (LAST_IDX - byte_idx) : byte_idx;
    asm_next = asm_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (slot == IDX_W'(i)) asm_next[8*i +: 8] = rx_byte;
    end
  end

  assign word_done = rcv && (byte_idx == LAST_IDX);
  assign can_load  = !word_valid || word_ready;
  assign tmo_hit   = TMO_EN && (state == COLLECT) && !rcv && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk12) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= '0;
      tmo_cnt     <= '0;
      asm_q       <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;

      if (rcv) begin
        asm_q   <= asm_next;
        tmo_cnt <= '0;
        if (byte_idx == LAST_IDX) begin
          byte_idx <= '0;
          state    <= IDLE;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          state    <= COLLECT;
        end
      end else if (tmo_hit) begin
        byte_idx    <= '0;
        state       <= IDLE;
        tmo_cnt     <= '0;
        timeout_err <= 1'b1;
      end else if (TMO_EN && state == COLLECT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      // A completing word may reuse the slot being drained this cycle.
      if (word_done) begin
        if (can_load) begin
          word_data  <= asm_next;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
